haar_stage_accumulator: RTL and testbench
=========================================

Name: haar_stage_accumulator

Overview:
- Consumes the weak-classifier stream of one Haar cascade stage and accumulates left/right votes into a signed stage sum.
- Each node is one feature response plus its ROM tuple: node threshold, left value, right value.
- At the end of the stream it compares the sum against the stage threshold and reports pass/fail.
- Sits directly downstream of the classifier address counter: it fires the counter's trigger_compare and consumes the node data fetched at the counter's addresses.

Parameters:
- FEAT_WIDTH, 16, signed width of feature value and node threshold.
- VOTE_WIDTH, 12, signed width of left/right vote values.
- SUM_WIDTH, 18, signed width of stage sum and stage threshold.
- CNT_WIDTH, 8, width of node counter; matches counter max_size width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begin a new stage evaluation.
- i_stage_threshold  in  SUM_WIDTH  signed; sampled on accepted i_start.
- o_trigger_compare  out  1  one-cycle pulse to the address counter.
- i_node_valid  in  1  node tuple valid this cycle.
- i_node_last  in  1  qualifies the final node of the stage; meaningful only with i_node_valid.
- i_feature_value  in  FEAT_WIDTH  signed feature response.
- i_node_threshold  in  FEAT_WIDTH  signed.
- i_left_val  in  VOTE_WIDTH  signed.
- i_right_val  in  VOTE_WIDTH  signed.
- o_busy  out  1  high in ACCUM and COMPARE.
- o_done  out  1  one-cycle pulse; result valid.
- o_pass  out  1  stage result; held until next accepted start.
- o_stage_sum  out  SUM_WIDTH  final signed sum; held with o_pass.
- o_node_count  out  CNT_WIDTH  nodes accepted in the current/last stage.
- o_saturated  out  1  sticky per stage; sum clipped at least once.

Behaviour:
- Reset: state IDLE; sum=0, threshold reg=0, o_trigger_compare=0, o_busy=0, o_done=0, o_pass=0, o_stage_sum=0, o_node_count=0, o_saturated=0. Reset mid-stage aborts immediately with no o_done.
- States:
  - IDLE -> ACCUM on i_start. In the same edge: clear sum, count, o_saturated and o_pass; latch i_stage_threshold; drive o_trigger_compare=1 for exactly the next cycle.
  - ACCUM: for each cycle with i_node_valid=1:
    - vote = (i_feature_value < i_node_threshold) ? i_left_val : i_right_val, signed compare.
    - Sign-extend vote to SUM_WIDTH+1 and add to sum.
    - Saturate to [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1]; set o_saturated when clipping occurs.
    - o_node_count += 1, wrapping at 2^CNT_WIDTH.
    - If i_node_last also =1, go to COMPARE.
  - COMPARE (1 cycle): pass = (sum >= threshold reg), signed compare. Register o_pass and o_stage_sum; pulse o_done next cycle; go to IDLE.
- Latency: node accepted with last in cycle T. Sum includes it at T+1 (state COMPARE). o_done=1, o_pass and o_stage_sum valid in cycle T+2. o_busy falls in cycle T+2.
- Back-to-back: i_start in the o_done cycle (state IDLE) is accepted.
- i_start while o_busy=1: ignored, no re-trigger.
- i_node_valid in IDLE or COMPARE: ignored; sum and count unchanged.
- i_node_last without i_node_valid: ignored.
- A zero-node stage cannot occur; at least one valid+last is required per stage.
- No backpressure: the block accepts a node every cycle in ACCUM.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=0, ACCUM=1, COMPARE=2, 2-bit state width.
  - Default widths FEAT_WIDTH, VOTE_WIDTH, SUM_WIDTH, CNT_WIDTH, shared with the counter and the feature ROM.
- One natural sub-module: haar_weak_vote_sat.
  - Combinational vote select plus saturating add.
  - Inputs: sum, feature, node threshold, left, right. Outputs: next sum, saturate flag.
  - Reusable by later cascade-stage blocks.

Test Plan:
- Reset then idle: all outputs 0; i_node_valid pulses in IDLE -> o_node_count stays 0, no o_done.
- Start, threshold=10, 3 nodes: (f=5,t=8,L=4,R=-2), (f=9,t=8,L=7,R=3), (f=-1,t=0,L=6,R=1), last on node 3 -> o_trigger_compare one cycle after start; o_stage_sum=13, o_pass=1, o_node_count=3, o_done exactly 2 cycles after last.
- Same nodes with threshold=14 -> o_stage_sum=13, o_pass=0. Boundary threshold=13 -> o_pass=1.
- Saturation, SUM_WIDTH=18: 70 nodes each voting +2047 -> o_stage_sum=131071, o_saturated=1. Mirror case with -2048 votes -> o_stage_sum=-131072.
- i_start mid-ACCUM -> ignored, sum continues. Reset asserted mid-ACCUM -> IDLE, no o_done, all outputs 0. Next stage runs clean.
- Back-to-back stages with start in the o_done cycle and i_node_valid gapped (valid every other cycle) -> correct independent sums, and o_saturated cleared between stages.

Source files
------------

// File: rtl/haar_stage_accumulator_pkg.sv
// Shared definitions for the Haar cascade stage datapath: default widths
// (common with the classifier address counter and the feature ROM) and the
// stage-accumulator state encoding.
package haar_stage_accumulator_pkg;

  localparam int DEF_FEAT_WIDTH = 16;  // feature value / node threshold
  localparam int DEF_VOTE_WIDTH = 12;  // left / right vote values
  localparam int DEF_SUM_WIDTH  = 18;  // stage sum / stage threshold
  localparam int DEF_CNT_WIDTH  = 8;   // node counter, matches counter max_size
  localparam int STATE_WIDTH    = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2
  } state_e;

endpackage

// File: rtl/haar_weak_vote_sat.sv
// One weak-classifier step: pick the left or right vote from a signed
// feature/threshold compare and add it to the running stage sum with
// saturation to the signed SUM_WIDTH range. Purely combinational so later
// cascade-stage blocks can reuse it in their own pipelines.
module haar_weak_vote_sat #(
  parameter int FEAT_WIDTH = haar_stage_accumulator_pkg::DEF_FEAT_WIDTH,
  parameter int VOTE_WIDTH = haar_stage_accumulator_pkg::DEF_VOTE_WIDTH,
  parameter int SUM_WIDTH  = haar_stage_accumulator_pkg::DEF_SUM_WIDTH
) (
  input  logic signed [SUM_WIDTH-1:0]  sum_i,
  input  logic signed [FEAT_WIDTH-1:0] feature_i,
  input  logic signed [FEAT_WIDTH-1:0] node_threshold_i,
  input  logic signed [VOTE_WIDTH-1:0] left_val_i,
  input  logic signed [VOTE_WIDTH-1:0] right_val_i,
  output logic signed [SUM_WIDTH-1:0]  sum_o,
  output logic                         sat_o
);

  localparam logic [SUM_WIDTH-1:0] SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic [SUM_WIDTH-1:0] SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  logic signed [VOTE_WIDTH-1:0] vote;
  logic        [SUM_WIDTH:0]    wide;

  // Vote select, one-bit-wider add, clip when the two top bits disagree.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path (defaults
    // first); otherwise synthesis infers a latch to hold the old value.
    sat_o = 1'b0;
    vote  = (feature_i < node_threshold_i) ? left_val_i : right_val_i;
    wide  = {sum_i[SUM_WIDTH-1], sum_i}
          + {{(SUM_WIDTH+1-VOTE_WIDTH){vote[VOTE_WIDTH-1]}}, vote};
    sum_o = wide[SUM_WIDTH-1:0];
    if (wide[SUM_WIDTH] != wide[SUM_WIDTH-1]) begin
      sat_o = 1'b1;
      sum_o = wide[SUM_WIDTH] ? SUM_MIN : SUM_MAX;
    end
  end

endmodule

// File: rtl/haar_stage_accumulator.sv
// Accumulates the weak-classifier votes of one Haar cascade stage and
// reports pass/fail against the stage threshold. The start edge fires the
// address counter's trigger_compare; node tuples then arrive at one per
// cycle at most, with no backpressure, until the one flagged last.
module haar_stage_accumulator
  import haar_stage_accumulator_pkg::*;
#(
  parameter int FEAT_WIDTH = haar_stage_accumulator_pkg::DEF_FEAT_WIDTH,
  parameter int VOTE_WIDTH = haar_stage_accumulator_pkg::DEF_VOTE_WIDTH,
  parameter int SUM_WIDTH  = haar_stage_accumulator_pkg::DEF_SUM_WIDTH,
  parameter int CNT_WIDTH  = haar_stage_accumulator_pkg::DEF_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic signed [SUM_WIDTH-1:0]  i_stage_threshold,
  output logic                         o_trigger_compare,
  input  logic                         i_node_valid,
  input  logic                         i_node_last,
  input  logic signed [FEAT_WIDTH-1:0] i_feature_value,
  input  logic signed [FEAT_WIDTH-1:0] i_node_threshold,
  input  logic signed [VOTE_WIDTH-1:0] i_left_val,
  input  logic signed [VOTE_WIDTH-1:0] i_right_val,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_pass,
  output logic signed [SUM_WIDTH-1:0]  o_stage_sum,
  output logic [CNT_WIDTH-1:0]         o_node_count,
  output logic                         o_saturated
);

  state_e                      state_q, state_d;
  logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
  logic signed [SUM_WIDTH-1:0] thr_q, thr_d;
  logic signed [SUM_WIDTH-1:0] stage_sum_q, stage_sum_d;
  logic [CNT_WIDTH-1:0]        count_q, count_d;
  logic                        trig_q, trig_d;
  logic                        done_q, done_d;
  logic                        pass_q, pass_d;
  logic                        sat_q, sat_d;

  logic signed [SUM_WIDTH-1:0] vote_sum;
  logic                        vote_sat;

  haar_weak_vote_sat #(
    .FEAT_WIDTH (FEAT_WIDTH),
    .VOTE_WIDTH (VOTE_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH)
  ) u_vote (
    .sum_i            (sum_q),
    .feature_i        (i_feature_value),
    .node_threshold_i (i_node_threshold),
    .left_val_i       (i_left_val),
    .right_val_i      (i_right_val),
    .sum_o            (vote_sum),
    .sat_o            (vote_sat)
  );

  // Next-state and datapath update for IDLE -> ACCUM -> COMPARE -> IDLE.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    thr_d       = thr_q;
    stage_sum_d = stage_sum_q;
    count_d     = count_q;
    pass_d      = pass_q;
    sat_d       = sat_q;
    trig_d      = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ACCUM;
          sum_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          pass_d  = 1'b0;
          thr_d   = i_stage_threshold;
          trig_d  = 1'b1;
        end
      end
      ST_ACCUM: begin
        // A start here is deliberately ignored: the stage is already running.
        if (i_node_valid) begin
          sum_d   = vote_sum;
          sat_d   = sat_q | vote_sat;
          count_d = count_q + CNT_WIDTH'(1);
          if (i_node_last) state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        pass_d      = (sum_q >= thr_q);
        stage_sum_d = sum_q;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any stage in flight.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-high here, sampled only on clk,
    // so it matches the rest of the cascade pipeline.
    if (reset) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      thr_q       <= '0;
      stage_sum_q <= '0;
      count_q     <= '0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      sum_q       <= sum_d;
      thr_q       <= thr_d;
      stage_sum_q <= stage_sum_d;
      count_q     <= count_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      sat_q       <= sat_d;
    end
  end

  assign o_trigger_compare = trig_q;
  assign o_busy            = (state_q != ST_IDLE);
  assign o_done            = done_q;
  assign o_pass            = pass_q;
  assign o_stage_sum       = stage_sum_q;
  assign o_node_count      = count_q;
  assign o_saturated       = sat_q;

endmodule

// File: tb/tb_haar_stage_accumulator.sv
// Directed bench for haar_stage_accumulator. A transaction-level model turns
// each stage's node list into the expected sum/pass/count/saturation and the
// cycle o_done must appear; one monitor compares every cycle.
module tb_haar_stage_accumulator;
  import haar_stage_accumulator_pkg::*;

  localparam int FW = DEF_FEAT_WIDTH;
  localparam int VW = DEF_VOTE_WIDTH;
  localparam int SW = DEF_SUM_WIDTH;
  localparam int CW = DEF_CNT_WIDTH;
  localparam longint SMAX = 131071;
  localparam longint SMIN = -131072;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_start = 1'b0;
  logic signed [SW-1:0] i_stage_threshold = '0;
  logic                 o_trigger_compare;
  logic                 i_node_valid = 1'b0;
  logic                 i_node_last = 1'b0;
  logic signed [FW-1:0] i_feature_value = '0;
  logic signed [FW-1:0] i_node_threshold = '0;
  logic signed [VW-1:0] i_left_val = '0;
  logic signed [VW-1:0] i_right_val = '0;
  logic                 o_busy, o_done, o_pass, o_saturated;
  logic signed [SW-1:0] o_stage_sum;
  logic [CW-1:0]        o_node_count;

  haar_stage_accumulator dut (
    .clk               (clk),
    .reset             (reset),
    .i_start           (i_start),
    .i_stage_threshold (i_stage_threshold),
    .o_trigger_compare (o_trigger_compare),
    .i_node_valid      (i_node_valid),
    .i_node_last       (i_node_last),
    .i_feature_value   (i_feature_value),
    .i_node_threshold  (i_node_threshold),
    .i_left_val        (i_left_val),
    .i_right_val       (i_right_val),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_pass            (o_pass),
    .o_stage_sum       (o_stage_sum),
    .o_node_count      (o_node_count),
    .o_saturated       (o_saturated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    longint sum;
    longint pass;
    longint count;
    longint sat;
    int     done_cyc;
  } result_t;

  result_t exp_q[$];
  int      exp_trig_cyc = -1;
  longint  cur_thr = 0;
  int      n_cmp = 0;
  int      n_bad = 0;

  int nf[300], nt[300], nl[300], nr[300];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Stage result straight from the rules: sum of chosen votes, clamped after
  // each addition, compared against the threshold.
  function automatic result_t model(input longint thr, input int n);
    result_t r;
    longint s = 0;
    longint sat = 0;
    for (int i = 0; i < n; i++) begin
      longint v = (nf[i] < nt[i]) ? longint'(nl[i]) : longint'(nr[i]);
      s = s + v;
      if (s > SMAX) begin s = SMAX; sat = 1; end
      if (s < SMIN) begin s = SMIN; sat = 1; end
    end
    r.sum = s;
    r.pass = (s >= thr) ? 1 : 0;
    r.count = n % 256;
    r.sat = sat;
    r.done_cyc = -1;
    return r;
  endfunction

  function automatic void set_test_nodes();
    nf[0] = 5;  nt[0] = 8; nl[0] = 4; nr[0] = -2;
    nf[1] = 9;  nt[1] = 8; nl[1] = 7; nr[1] = 3;
    nf[2] = -1; nt[2] = 0; nl[2] = 6; nr[2] = 1;
  endfunction

  // Every node takes the left vote; the right vote is the opposite extreme.
  function automatic void set_const_nodes(input int n, input int lv, input int rv);
    for (int i = 0; i < n; i++) begin
      nf[i] = -3; nt[i] = 7; nl[i] = lv; nr[i] = rv;
    end
  endfunction

  function automatic void set_wrap_nodes(input int n);
    for (int i = 0; i < n; i++) begin
      nf[i] = (i % 3) - 1; nt[i] = 0; nl[i] = 5; nr[i] = -3;
    end
  endfunction

  task automatic start_stage(input longint thr);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_stage_threshold = SW'(thr);
    cur_thr = thr;
    exp_trig_cyc = cyc + 1;
  endtask

  // Drives n nodes; optional idle gap (with a stray last) between nodes and
  // an ignored start pulse at node index bogus_at.
  task automatic drive_nodes(input int n, input bit gap, input bit with_last, input int bogus_at);
    result_t r;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_start = (i == bogus_at);
      if (i == bogus_at) i_stage_threshold = SW'(100000);
      i_node_valid = 1'b1;
      i_node_last = with_last && (i == n - 1);
      i_feature_value = FW'(nf[i]);
      i_node_threshold = FW'(nt[i]);
      i_left_val = VW'(nl[i]);
      i_right_val = VW'(nr[i]);
      if (i_node_last) begin
        r = model(cur_thr, n);
        r.done_cyc = cyc + 2;
        exp_q.push_back(r);
      end
      if (gap && i != n - 1) begin
        @(posedge clk); #1;
        i_start = 1'b0;
        i_node_valid = 1'b0;
        i_node_last = 1'b1;
      end
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    i_node_valid = 1'b0;
    i_node_last = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge clk);
    check("settle_pending_results", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trigger"}, o_trigger_compare, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_sum"}, longint'(o_stage_sum), 0);
    check({tag, "_count"}, o_node_count, 0);
    check({tag, "_sat"}, o_saturated, 0);
  endtask

  // Cycle-by-cycle compare against the expected trigger/done timeline.
  always @(negedge clk) begin
    if (!reset) begin
      check("trigger_pulse", o_trigger_compare, (cyc == exp_trig_cyc) ? 1 : 0);
      if (exp_q.size() != 0 && exp_q[0].done_cyc == cyc) begin
        result_t r;
        r = exp_q.pop_front();
        check("done_pulse", o_done, 1);
        check("stage_sum", longint'(o_stage_sum), r.sum);
        check("pass", o_pass, r.pass);
        check("node_count", o_node_count, r.count);
        check("saturated", o_saturated, r.sat);
        check("busy_at_done", o_busy, 0);
      end else begin
        check("done_pulse", o_done, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    result_t m;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Node pulses while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      i_node_valid = 1'b1; i_node_last = (i == 2);
      i_left_val = VW'(100);
    end
    @(posedge clk); #1;
    i_node_valid = 1'b0; i_node_last = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_count", o_node_count, 0);
    check("idle_busy", o_busy, 0);

    // Pin the model with hand-computed values.
    set_test_nodes();
    m = model(10, 3);
    check("model_basic_sum", m.sum, 13);
    check("model_basic_pass", m.pass, 1);
    m = model(14, 3);
    check("model_thr14_pass", m.pass, 0);
    set_const_nodes(70, 2047, -2048);
    m = model(0, 70);
    check("model_sat_pos", m.sum, 131071);
    set_const_nodes(70, -2048, 2047);
    m = model(0, 70);
    check("model_sat_neg", m.sum, -131072);
    set_wrap_nodes(258);
    m = model(0, 258);
    check("model_wrap_sum", m.sum, -86);
    check("model_wrap_count", m.count, 2);

    // Basic stage, threshold above, and boundary threshold.
    set_test_nodes();
    start_stage(10); drive_nodes(3, 0, 1, -1); settle();
    check("basic_sum_literal", longint'(o_stage_sum), 13);
    check("basic_pass_literal", o_pass, 1);
    check("basic_count_literal", o_node_count, 3);
    start_stage(14); drive_nodes(3, 0, 1, -1); settle();
    check("thr14_pass_literal", o_pass, 0);
    start_stage(13); drive_nodes(3, 0, 1, -1); settle();
    check("thr13_pass_literal", o_pass, 1);

    // Saturation both directions.
    set_const_nodes(70, 2047, -2048);
    start_stage(0); drive_nodes(70, 0, 1, -1); settle();
    check("satpos_sum_literal", longint'(o_stage_sum), 131071);
    check("satpos_flag_literal", o_saturated, 1);
    set_const_nodes(70, -2048, 2047);
    start_stage(0); drive_nodes(70, 0, 1, -1); settle();
    check("satneg_sum_literal", longint'(o_stage_sum), -131072);

    // Start mid-ACCUM is ignored (no retrigger, threshold kept).
    set_test_nodes();
    start_stage(10); drive_nodes(3, 0, 1, 1); settle();
    check("midstart_pass_literal", o_pass, 1);

    // Reset mid-ACCUM aborts with no o_done.
    start_stage(10); drive_nodes(2, 0, 0, -1);
    @(negedge clk);
    check("abort_busy_before_reset", o_busy, 1);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    repeat (4) @(negedge clk);

    // Clean stage after the abort.
    start_stage(13); drive_nodes(3, 0, 1, -1); settle();

    // Node counter wrap.
    set_wrap_nodes(258);
    start_stage(-86); drive_nodes(258, 0, 1, -1); settle();
    check("wrap_count_literal", o_node_count, 2);

    // Back-to-back, gapped: saturating stage, then a start in its o_done cycle.
    set_const_nodes(70, 2047, -2048);
    start_stage(0); drive_nodes(70, 1, 1, -1);
    set_test_nodes();
    start_stage(14); drive_nodes(3, 1, 1, -1); settle();
    check("b2b_sat_cleared_literal", o_saturated, 0);
    check("b2b_sum_literal", longint'(o_stage_sum), 13);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
